fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined CPU, directly upstream of the decode stage inside cpu_top.
- Generates sequential PCs and issues requests to the instruction memory port.
- Buffers returned instructions in a small in-order FIFO and presents {o_pipe_PC, o_pipe_Instruction} to decode with a valid/ready handshake.
- Accepts redirects from execute (taken branch/jump) and discards stale in-flight fetches.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector, NOP encoding and small helpers.
package cpu_pkg;

   localparam int unsigned DefaultXlen = 32;
   localparam int unsigned Ilen        = 32;

   localparam logic [DefaultXlen-1:0] DefaultResetPc = 32'h0000_0000;
   localparam logic [Ilen-1:0]        NopInstr       = 32'h0000_0013;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
      return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with flush; power-of-two depth so the pointers wrap naturally.
module fetch_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [Width-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [Width-1:0]       rdata_o,
   output logic [$clog2(Depth):0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d;
   logic [PtrW-1:0]  rptr_q, rptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_i & (count_q != '0);
   // A full FIFO may still take a push when the head leaves in the same cycle.
   assign do_push = push_i & ((count_q != CntW'(Depth)) | do_pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PtrW'(1);
         if (do_pop)  rptr_d = rptr_q + PtrW'(1);
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, in-order buffering, redirect flush.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned      XLEN      = DefaultXlen,
   parameter int unsigned      BUF_DEPTH = 2,
   parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DefaultResetPc)
) (
   input  logic            clk,
   input  logic            reset,
   output logic            o_imem_req_valid,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_req_ready,
   input  logic            i_imem_rsp_valid,
   input  logic [XLEN-1:0] i_imem_rsp_data,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_pipe_valid,
   output logic [XLEN-1:0] o_pipe_PC,
   output logic [XLEN-1:0] o_pipe_Instruction,
   input  logic            i_pipe_ready
);

   localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [CntW-1:0]   outstanding_q, outstanding_d;
   logic [CntW-1:0]   drop_q, drop_d;
   logic [CntW-1:0]   fifo_count, pcq_count;
   logic [XLEN-1:0]   pcq_head;
   logic [2*XLEN-1:0] fifo_head;
   logic              req_fire, rsp_seen, rsp_keep, rsp_drop, pipe_pop;

   // Outstanding counts every in-flight fetch, including those already marked for dropping.
   assign o_imem_req_valid = reset & ~i_redirect_valid &
                             ((fifo_count + outstanding_q) < CntW'(BUF_DEPTH));
   assign o_imem_req_addr  = fetch_pc_q;
   assign req_fire         = o_imem_req_valid & i_imem_req_ready;

   // Responses with nothing outstanding are stale (e.g. issued before a reset) and ignored.
   assign rsp_seen = i_imem_rsp_valid & (outstanding_q != '0);
   assign rsp_keep = rsp_seen & ~i_redirect_valid & (drop_q == '0) & (pcq_count != '0);
   assign rsp_drop = rsp_seen & ~rsp_keep;
   assign pipe_pop = o_pipe_valid & i_pipe_ready;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      if (i_redirect_valid) begin
         fetch_pc_d    = {i_redirect_pc[XLEN-1:2], 2'b00};
         outstanding_d = outstanding_q - CntW'(rsp_seen);
         drop_d        = outstanding_d;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
         outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_seen);
         if (rsp_seen && (drop_q != '0)) drop_d = drop_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fetch_fifo #(
      .Width (XLEN),
      .Depth (BUF_DEPTH)
   ) u_pc_queue (
      .clk_i   (clk),
      .rst_ni  (reset),
      .flush_i (i_redirect_valid),
      .push_i  (req_fire),
      .wdata_i (fetch_pc_q),
      .pop_i   (rsp_keep),
      .rdata_o (pcq_head),
      .count_o (pcq_count)
   );

   fetch_fifo #(
      .Width (2 * XLEN),
      .Depth (BUF_DEPTH)
   ) u_inst_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .flush_i (i_redirect_valid),
      .push_i  (rsp_keep),
      .wdata_i ({pcq_head, i_imem_rsp_data}),
      .pop_i   (pipe_pop),
      .rdata_o (fifo_head),
      .count_o (fifo_count)
   );

   assign o_pipe_valid       = (fifo_count != '0);
   assign o_pipe_PC          = fifo_head[2*XLEN-1:XLEN];
   assign o_pipe_Instruction = fifo_head[XLEN-1:0];

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] drop_cnt_q, drop_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] fetch_cnt, drop_cnt, stall_cnt;

   always_comb begin
      fetch_cnt_d = sat_inc32(fetch_cnt_q, req_fire);
      drop_cnt_d  = sat_inc32(drop_cnt_q, rsp_drop);
      stall_cnt_d = sat_inc32(stall_cnt_q, o_pipe_valid & ~i_pipe_ready);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= '0;
         drop_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   logic unused_drop;
   assign unused_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based fetch model checked every cycle, plus directed literal checks.
module tb_fetch_unit;

   localparam int unsigned   BufDepth = 2;
   localparam logic [31:0]   ResetPc  = 32'h0000_0000;

   logic        clk, reset;
   logic        req_valid, req_ready, rsp_valid, redir_valid, pipe_valid, pipe_ready;
   logic [31:0] req_addr, rsp_data, redir_pc, pipe_pc, pipe_instr;

   fetch_unit #(
      .XLEN      (32),
      .BUF_DEPTH (BufDepth),
      .RESET_PC  (ResetPc)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .o_imem_req_valid   (req_valid),
      .o_imem_req_addr    (req_addr),
      .i_imem_req_ready   (req_ready),
      .i_imem_rsp_valid   (rsp_valid),
      .i_imem_rsp_data    (rsp_data),
      .i_redirect_valid   (redir_valid),
      .i_redirect_pc      (redir_pc),
      .o_pipe_valid       (pipe_valid),
      .o_pipe_PC          (pipe_pc),
      .o_pipe_Instruction (pipe_instr),
      .i_pipe_ready       (pipe_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {logic [31:0] addr; bit stale;} inflight_t;
   typedef struct {logic [31:0] pc; logic [31:0] ins;} entry_t;
   typedef struct {logic [31:0] addr; int due;} memreq_t;

   inflight_t   inflight[$];
   entry_t      bufq[$];
   memreq_t     memq[$];
   logic [31:0] popped[$];
   logic [31:0] m_pc;
   int          m_fetch, m_drop, m_stall;
   int          checks, errors, cyc, lat, ready_mode, accepts, stale_cnt;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_pop(input string name, input int idx, input logic [31:0] exp);
      if (popped.size() > idx) begin
         chk(name, popped[idx], exp);
      end else begin
         checks++;
         errors++;
         $display("FAIL %s: only %0d instructions delivered, needed index %0d", name,
                  popped.size(), idx);
      end
   endtask

   task automatic model_reset();
      bufq.delete();
      inflight.delete();
      m_pc    = ResetPc;
      m_fetch = 0;
      m_drop  = 0;
      m_stall = 0;
   endtask

   task automatic reset_literals(input string tag);
      chk({tag, "_pipe_valid"}, pipe_valid, 0);
      chk({tag, "_pipe_pc"}, pipe_pc, 0);
      chk({tag, "_pipe_instr"}, pipe_instr, 0);
      chk({tag, "_req_valid"}, req_valid, 0);
      chk({tag, "_req_addr"}, req_addr, ResetPc);
   endtask

   // One clock cycle: drive memory, compare against the model, then advance the model.
   task automatic cycle();
      bit        exp_req, had_head;
      inflight_t e;
      rsp_valid = 1'b0;
      rsp_data  = '0;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = instr_of(memq[0].addr);
      end
      req_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      #1;
      exp_req  = reset && !redir_valid && (bufq.size() + inflight.size() < BufDepth);
      had_head = bufq.size() > 0;
      chk("req_valid", req_valid, exp_req);
      chk("req_addr", req_addr, m_pc);
      chk("pipe_valid", pipe_valid, had_head);
      if (had_head) begin
         chk("pipe_pc", pipe_pc, bufq[0].pc);
         chk("pipe_instr", pipe_instr, bufq[0].ins);
      end
      // Environment bookkeeping follows what the DUT actually did.
      if (rsp_valid) void'(memq.pop_front());
      if (req_valid && req_ready) begin
         memq.push_back('{req_addr, cyc + lat});
         accepts++;
      end
      if (pipe_valid && pipe_ready) popped.push_back(pipe_pc);
      if (reset) begin
         if (had_head && !pipe_ready) m_stall++;
         if (had_head && pipe_ready) void'(bufq.pop_front());
         if (rsp_valid) begin
            if (inflight.size() == 0) begin
               stale_cnt++;
               $display("note: cycle %0d response with nothing outstanding ignored", cyc);
            end else begin
               e = inflight.pop_front();
               if (redir_valid || e.stale) m_drop++;
               else bufq.push_back('{e.addr, instr_of(e.addr)});
            end
         end
         if (redir_valid) begin
            bufq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_pc = {redir_pc[31:2], 2'b00};
         end else if (exp_req && req_ready) begin
            inflight.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
            m_fetch++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b0;
      #1;
      reset_literals("rst");
      model_reset();
      @(negedge clk);
      repeat (hold) cycle();
      reset = 1'b1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redir_valid = 1'b1;
      redir_pc    = pc;
      cycle();
      redir_valid = 1'b0;
   endtask

   initial begin
      int drop0, acc0;
      reset = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      redir_valid = 1'b0; redir_pc = '0; pipe_ready = 1'b1;
      checks = 0; errors = 0; cyc = 0; lat = 1; ready_mode = 0; accepts = 0; stale_cnt = 0;
      model_reset();
      @(negedge clk);
      do_reset(2);

      // Streaming with a 1-cycle memory: first instruction valid two cycles after issue.
      popped.delete();
      cycle();
      chk("t1_empty_cycle1", pipe_valid, 0);
      cycle();
      chk("t1_valid_cycle2", pipe_valid, 1);
      chk("t1_pc_cycle2", pipe_pc, 32'h0);
      chk("t1_ins_cycle2", pipe_instr, instr_of(32'h0));
      repeat (10) cycle();
      chk_pop("t1_pc0", 0, 32'h0);
      chk_pop("t1_pc1", 1, 32'h4);
      chk_pop("t1_pc2", 2, 32'h8);
      chk_pop("t1_pc3", 3, 32'hC);

      // Decode stalled: credits cap the fetch at BUF_DEPTH and the head holds.
      do_reset(1);
      pipe_ready = 1'b0;
      acc0 = accepts;
      repeat (6) cycle();
      chk("t2_accepts", accepts - acc0, BufDepth);
      chk("t2_held_pc", pipe_pc, 32'h0);
      chk("t2_held_ins", pipe_instr, instr_of(32'h0));
      chk("t2_no_req", req_valid, 0);
      pipe_ready = 1'b1;
      popped.delete();
      repeat (6) cycle();
      chk_pop("t2_pc0", 0, 32'h0);
      chk_pop("t2_pc1", 1, 32'h4);
      chk_pop("t2_pc2", 2, 32'h8);

      // Redirect with two fetches in flight.
      lat = 3;
      for (int n = 0; n < 12; n++) begin
         if (inflight.size() == BufDepth) break;
         cycle();
      end
      chk("t3_two_in_flight", inflight.size(), BufDepth);
      drop0 = m_drop;
`ifdef FETCH_PERF_EN
      drop0 = dut.drop_cnt;
`endif
      redirect(32'h100);
      chk("t3_valid_after_redirect", pipe_valid, 0);
      popped.delete();
      repeat (14) cycle();
      chk_pop("t3_pc0", 0, 32'h100);
      chk_pop("t3_pc1", 1, 32'h104);
`ifdef FETCH_PERF_EN
      chk("t3_drop_cnt", dut.drop_cnt - drop0, 2);
`endif

      // Redirect coinciding with a response, then a second redirect the next cycle.
      lat = 1;
      repeat (4) cycle();
      for (int n = 0; n < 8; n++) begin
         if (memq.size() > 0 && memq[0].due <= cyc) break;
         cycle();
      end
      redirect(32'h200);
      redirect(32'h301);
      chk("t4_valid_after_redirect", pipe_valid, 0);
      popped.delete();
      repeat (8) cycle();
      chk_pop("t4_pc0", 0, 32'h300);
      chk_pop("t4_pc1", 1, 32'h304);

      // Back-pressure on both sides with a 3-cycle memory.
      redirect(32'h400);
      popped.delete();
      lat = 3;
      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
         pipe_ready = (n % 3) != 0;
         cycle();
      end
      pipe_ready = 1'b1;
      ready_mode = 0;
      repeat (10) cycle();
      chk("t5_enough_delivered", popped.size() >= 8, 1);
      for (int i = 0; i < popped.size(); i++)
         chk("t5_sequence", popped[i], 32'h400 + 32'(4 * i));
`ifdef FETCH_PERF_EN
      chk("perf_fetch_cnt", dut.fetch_cnt, m_fetch);
      chk("perf_drop_cnt", dut.drop_cnt, m_drop);
      chk("perf_stall_cnt", dut.stall_cnt, m_stall);
`endif

      // Reset mid-stream with responses still pending in memory.
      lat = 3;
      repeat (6) cycle();
      chk("t6_rsp_pending", memq.size() > 0, 1);
      reset = 1'b0;
      #1;
      reset_literals("t6_rst");
      model_reset();
      @(negedge clk);
      for (int n = 0; n < 20; n++) begin
         if (memq.size() == 0 || (memq.size() == 1 && memq[0].due <= cyc)) break;
         cycle();
      end
      stale_cnt = 0;
      reset = 1'b1;
      popped.delete();
      repeat (10) cycle();
      chk("t6_stale_rsp_seen", stale_cnt > 0, 1);
      chk_pop("t6_pc0", 0, ResetPc);
      chk_pop("t6_pc1", 1, ResetPc + 32'd4);
`ifdef FETCH_PERF_EN
      chk("perf_fetch_cnt_end", dut.fetch_cnt, m_fetch);
      chk("perf_drop_cnt_end", dut.drop_cnt, m_drop);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
